// File: rtl/spi_byte_rx_pkg.sv
// Shared constants for the SPI slave receive path.
// Holds DC encoding, byte width and pin-sync defaults.
package spi_byte_rx_pkg;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   localparam int BYTE_W    = 8;
   localparam int BIT_CNT_W = $clog2(BYTE_W);

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_FILT_LEN    = 3;

endpackage

// File: rtl/pin_sync_filt.sv
// Single-bit pin synchroniser with optional deglitch filter.
// Without the filter, a FILT_LEN-deep delay line keeps alignment.
module pin_sync_filt
   import spi_byte_rx_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN,
   parameter bit FILTER      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s;

   // shift the raw pin through the synchroniser chain
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // synchroniser register
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign s = sync_q[SYNC_STAGES-1];

   generate
      if (FILTER) begin : g_filt
         localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

         logic [CW-1:0] cnt_q, cnt_d;
         logic          lvl_q, lvl_d;

         // level changes only after FILT_LEN cycles of disagreement
         always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (s != lvl_q) begin
               if (cnt_q == CW'(FILT_LEN - 1)) lvl_d = s;
               else                            cnt_d = cnt_q + CW'(1);
            end
         end

         // filter state register
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q <= '0;
               lvl_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               lvl_q <= lvl_d;
            end
         end

         assign q = lvl_q;
      end else if (FILT_LEN > 0) begin : g_dly
         logic [FILT_LEN-1:0] dly_q, dly_d;

         // delay line matching the filter latency
         always_comb begin
            dly_d    = dly_q;
            dly_d[0] = s;
            for (int i = 1; i < FILT_LEN; i++) begin
               dly_d[i] = dly_q[i-1];
            end
         end

         // delay line register
         always_ff @(posedge clk) begin
            if (rst) dly_q <= '0;
            else     dly_q <= dly_d;
         end

         assign q = dly_q[FILT_LEN-1];
      end else begin : g_pass
         assign q = s;
      end
   endgenerate

endmodule

// File: rtl/spi_byte_rx.sv
// SPI slave receive front end: pin sync, clock deglitch,
// MSB-first byte assembly and frame bookkeeping.
module spi_byte_rx
   import spi_byte_rx_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int FILT_LEN    = DEF_FILT_LEN,
   parameter int CNT_W       = 16
) (
   input  logic              SCLK,
   input  logic              Rst,
   input  logic              SPI_CLK,
   input  logic              SPI_DATA,
   input  logic              LE,
   input  logic              DC_in,
   output logic              write,
   output logic [7:0]        SHIFT_REG,
   output logic              DC_out,
   output logic              frame_start,
   output logic              frame_end,
   output logic              err_partial,
   output logic [CNT_W-1:0]  byte_cnt
);

   logic clk_f, data_al, dc_al, le_s;

   pin_sync_filt #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .FILTER(1'b1)
   ) u_clk (
      .clk(SCLK), .rst(Rst), .pin(SPI_CLK), .q(clk_f)
   );

   pin_sync_filt #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .FILTER(1'b0)
   ) u_data (
      .clk(SCLK), .rst(Rst), .pin(SPI_DATA), .q(data_al)
   );

   pin_sync_filt #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .FILTER(1'b0)
   ) u_dc (
      .clk(SCLK), .rst(Rst), .pin(DC_in), .q(dc_al)
   );

   pin_sync_filt #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(0), .FILTER(1'b0)
   ) u_le (
      .clk(SCLK), .rst(Rst), .pin(LE), .q(le_s)
   );

   logic                 clk_prev_q, clk_prev_d;
   logic                 le_prev_q, le_prev_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-2:0]    sh_q, sh_d;
   logic [BYTE_W-1:0]    shift_reg_q, shift_reg_d;
   logic                 dc_out_q, dc_out_d;
   logic                 write_q, write_d;
   logic                 fs_q, fs_d;
   logic                 fe_q, fe_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;

   logic rise, le_rise, le_fall;

   assign rise    = clk_f & ~clk_prev_q & le_s;
   assign le_rise = le_s & ~le_prev_q;
   assign le_fall = ~le_s & le_prev_q;

   // frame edges take precedence; otherwise shift on a qualified rise
   always_comb begin
      clk_prev_d  = clk_f;
      le_prev_d   = le_s;
      bit_cnt_d   = bit_cnt_q;
      sh_d        = sh_q;
      shift_reg_d = shift_reg_q;
      dc_out_d    = dc_out_q;
      byte_cnt_d  = byte_cnt_q;
      write_d     = 1'b0;
      fs_d        = 1'b0;
      fe_d        = 1'b0;
      err_d       = 1'b0;
      if (le_rise) begin
         fs_d       = 1'b1;
         byte_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (le_fall) begin
         fe_d      = 1'b1;
         err_d     = (bit_cnt_q != '0);
         bit_cnt_d = '0;
      end else if (rise) begin
         sh_d      = {sh_q[BYTE_W-3:0], data_al};
         bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
            write_d     = 1'b1;
            shift_reg_d = {sh_q, data_al};
            dc_out_d    = dc_al ? DC_DATA : DC_CMD;
            if (~&byte_cnt_q) byte_cnt_d = byte_cnt_q + CNT_W'(1);
         end
      end
   end

   // byte and frame state register
   always_ff @(posedge SCLK) begin
      if (Rst) begin
         clk_prev_q  <= 1'b0;
         le_prev_q   <= 1'b0;
         bit_cnt_q   <= '0;
         sh_q        <= '0;
         shift_reg_q <= '0;
         dc_out_q    <= DC_CMD;
         byte_cnt_q  <= '0;
         write_q     <= 1'b0;
         fs_q        <= 1'b0;
         fe_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_prev_q  <= clk_prev_d;
         le_prev_q   <= le_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         shift_reg_q <= shift_reg_d;
         dc_out_q    <= dc_out_d;
         byte_cnt_q  <= byte_cnt_d;
         write_q     <= write_d;
         fs_q        <= fs_d;
         fe_q        <= fe_d;
         err_q       <= err_d;
      end
   end

   assign write       = write_q;
   assign SHIFT_REG   = shift_reg_q;
   assign DC_out      = dc_out_q;
   assign frame_start = fs_q;
   assign frame_end   = fe_q;
   assign err_partial = err_q;
   assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx.
// Vector table, corner sequences and random frames vs a queue model.
`timescale 1ns/100ps
module tb_spi_byte_rx;

   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             SCLK = 1'b0;
   logic             Rst = 1'b1;
   logic             SPI_CLK = 1'b0;
   logic             SPI_DATA = 1'b0;
   logic             LE = 1'b0;
   logic             DC_in = 1'b0;
   logic             write;
   logic [7:0]       SHIFT_REG;
   logic             DC_out;
   logic             frame_start;
   logic             frame_end;
   logic             err_partial;
   logic [CNT_W-1:0] byte_cnt;

   spi_byte_rx #(
      .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CNT_W)
   ) dut (
      .SCLK(SCLK), .Rst(Rst), .SPI_CLK(SPI_CLK),
      .SPI_DATA(SPI_DATA), .LE(LE), .DC_in(DC_in),
      .write(write), .SHIFT_REG(SHIFT_REG), .DC_out(DC_out),
      .frame_start(frame_start), .frame_end(frame_end),
      .err_partial(err_partial), .byte_cnt(byte_cnt)
   );

   always #2.5 SCLK = ~SCLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge SCLK) cyc <= cyc + 1;

   logic [8:0] got_q[$];
   int n_fs = 0, n_fe = 0, n_err = 0, n_wr = 0;
   int err_alone = 0, wr_cyc = 0, rise_cyc = 0;
   int fs0, fe0, er0, w0;

   logic [7:0] tx_byte[300];
   bit         tx_dc[300];

   // observe outputs away from the active edge
   always @(negedge SCLK) begin
      if (!Rst) begin
         if (write) begin
            got_q.push_back({DC_out, SHIFT_REG});
            n_wr++;
            wr_cyc = cyc;
         end
         if (frame_start) n_fs++;
         if (frame_end) n_fe++;
         if (err_partial) begin
            n_err++;
            if (!frame_end) err_alone++;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge SCLK);
      #1;
   endtask

   task automatic send_bit(input bit b, input bit dc, input int lo,
                           input int hi, input bit mark);
      SPI_CLK  = 1'b0;
      SPI_DATA = b;
      DC_in    = dc;
      tick(lo);
      SPI_CLK = 1'b1;
      if (mark) rise_cyc = cyc;
      tick(hi);
   endtask

   // DC only matters on the 8th bit; earlier bits get noise
   task automatic send_bits(input logic [7:0] v, input int n,
                            input bit dc, input int hp);
      for (int i = 0; i < n; i++) begin
         send_bit(v[7-i], (i == 7) ? dc : 1'($urandom), hp, hp, i == 7);
      end
      SPI_CLK  = 1'b0;
      SPI_DATA = 1'b0;
      tick(hp);
   endtask

   task automatic run_frame(input int nb, input int pbits,
                            input logic [7:0] pval, input int hp);
      got_q.delete();
      fs0 = n_fs;
      fe0 = n_fe;
      er0 = n_err;
      w0  = n_wr;
      LE = 1'b1;
      tick(8);
      for (int b = 0; b < nb; b++) send_bits(tx_byte[b], 8, tx_dc[b], hp);
      if (pbits > 0) send_bits(pval, pbits, 1'b0, hp);
      tick(12);
      LE = 1'b0;
      tick(12);
   endtask

   // model: every full byte appears in order, count saturates
   task automatic check_frame(input string name, input int nb,
                              input int pbits);
      int n;
      n = (got_q.size() < nb) ? got_q.size() : nb;
      check({name, "_nwrites"}, got_q.size(), nb);
      for (int i = 0; i < n; i++) begin
         check({name, "_byte"}, got_q[i], {tx_dc[i], tx_byte[i]});
      end
      check({name, "_fstart"}, n_fs - fs0, 1);
      check({name, "_fend"}, n_fe - fe0, 1);
      check({name, "_err"}, n_err - er0, (pbits % 8) != 0);
      check({name, "_cnt"}, byte_cnt, (nb > CMAX) ? CMAX : nb);
   endtask

   typedef struct {
      logic [7:0] data;
      bit         dc;
      int         hp;
      int         nbits;
      int         exp_wr;
      logic [7:0] exp_sr;
      bit         exp_dc;
      bit         exp_err;
      int         exp_cnt;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{8'h00, 1'b1, 4,  8, 1, 8'h00, 1'b1, 1'b0, 1};
      vt[1] = '{8'hFF, 1'b0, 6,  8, 1, 8'hFF, 1'b0, 1'b0, 1};
      vt[2] = '{8'hC3, 1'b1, 10, 5, 0, 8'hFF, 1'b0, 1'b1, 0};
      vt[3] = '{8'h96, 1'b1, 20, 8, 1, 8'h96, 1'b1, 1'b0, 1};
      vt[4] = '{8'h01, 1'b0, 4,  1, 0, 8'h96, 1'b1, 1'b1, 0};
      vt[5] = '{8'h7E, 1'b0, 5,  8, 1, 8'h7E, 1'b0, 1'b0, 1};

      // reset held while pins toggle
      for (int i = 0; i < 5; i++) begin
         @(posedge SCLK);
         #1;
         SPI_CLK  = 1'($urandom);
         SPI_DATA = 1'($urandom);
         LE       = 1'($urandom);
         DC_in    = 1'($urandom);
         @(negedge SCLK);
         check("reset_outs",
               {write, SHIFT_REG, DC_out, frame_start,
                frame_end, err_partial, byte_cnt}, '0);
      end
      SPI_CLK = 0; SPI_DATA = 0; LE = 0; DC_in = 0;
      tick(1);
      Rst = 1'b0;
      tick(10);
      check("post_reset_pulses", n_fs + n_fe + n_err + n_wr, 0);

      // two-byte frame at 10 MHz
      tx_byte[0] = 8'hA5; tx_dc[0] = 1'b0;
      tx_byte[1] = 8'h3C; tx_dc[1] = 1'b1;
      run_frame(2, 0, 8'h00, 10);
      check_frame("two_bytes", 2, 0);
      check("latency", wr_cyc - rise_cyc, 6);

      // table of single-byte or partial frames
      for (int k = 0; k < 6; k++) begin
         tx_byte[0] = vt[k].data;
         tx_dc[0]   = vt[k].dc;
         if (vt[k].nbits == 8) run_frame(1, 0, 8'h00, vt[k].hp);
         else run_frame(0, vt[k].nbits, vt[k].data, vt[k].hp);
         check("tbl_writes", n_wr - w0, vt[k].exp_wr);
         check("tbl_shreg", SHIFT_REG, vt[k].exp_sr);
         check("tbl_dc", DC_out, vt[k].exp_dc);
         check("tbl_err", n_err - er0, vt[k].exp_err);
         check("tbl_cnt", byte_cnt, vt[k].exp_cnt);
      end

      // 2-cycle glitches ignored, a 3-cycle pulse is a bit
      got_q.delete();
      fs0 = n_fs; fe0 = n_fe; er0 = n_err;
      tx_byte[0] = 8'h81; tx_dc[0] = 1'b1;
      LE = 1'b1;
      tick(8);
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) begin
            SPI_CLK = 1'b1;
            tick(2);
            SPI_CLK = 1'b0;
            tick(5);
         end
         send_bit(tx_byte[0][7-i], 1'b1, 5, (i == 3) ? 3 : 5, i == 7);
      end
      SPI_CLK = 1'b0;
      tick(16);
      LE = 1'b0;
      tick(12);
      check_frame("glitch", 1, 0);

      // partial byte then a clean 0xFF frame
      run_frame(0, 5, 8'hB7, 8);
      check_frame("partial", 0, 5);
      tx_byte[0] = 8'hFF; tx_dc[0] = 1'b1;
      run_frame(1, 0, 8'h00, 8);
      check_frame("after_partial", 1, 0);

      // random frames
      for (int f = 0; f < 20; f++) begin
         int nb, pb, hp;
         nb = $urandom_range(0, 4);
         pb = $urandom_range(0, 7);
         hp = $urandom_range(4, 12);
         for (int b = 0; b < nb; b++) begin
            tx_byte[b] = 8'($urandom);
            tx_dc[b]   = 1'($urandom);
         end
         run_frame(nb, pb, 8'($urandom), hp);
         check_frame("rand", nb, pb);
      end

      // reset in the middle of a byte
      er0 = n_err;
      LE = 1'b1;
      tick(8);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 6, 6, 1'b0);
      SPI_CLK = 1'b0;
      tick(2);
      Rst = 1'b1;
      tick(3);
      Rst = 1'b0;
      tick(10);
      got_q.delete();
      send_bits(8'h5A, 8, 1'b0, 6);
      tick(12);
      LE = 1'b0;
      tick(12);
      check("rst_mid_nwrites", got_q.size(), 1);
      if (got_q.size() > 0) check("rst_mid_byte", got_q[0], {1'b0, 8'h5A});
      check("rst_mid_err", n_err - er0, 0);
      check("rst_mid_cnt", byte_cnt, 1);

      // counter saturation, then clear on the next frame
      for (int b = 0; b < 260; b++) begin
         tx_byte[b] = 8'($urandom);
         tx_dc[b]   = 1'($urandom);
      end
      run_frame(260, 0, 8'h00, 4);
      check_frame("sat", 260, 0);
      run_frame(0, 0, 8'h00, 4);
      check_frame("sat_clear", 0, 0);

      check("err_without_end", err_alone, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
